dff_exerciser: RTL and testbench
================================

# dff_exerciser

Stimulus generator and checker that drives the clock and data pins of a gate-level edge-triggered D flip-flop and reads back its `q`/`notq`. It is the driving end of the flop's interface. It applies a pseudo-random bit stream, disturbs `d` while the flop clock is high to prove edge (not level) capture, and counts mismatches. It sits in the lab top level between the board clock/reset/key logic and the flop under test, with `pass`/`done` routed to LEDs.

## Interface
- `PHASE_CYC`, default 4: system-clock cycles per drive phase. Legal range 3..255; the minimum of 3 covers the 2-flop input synchronizer.
- `NUM_VECT`, default 256: vectors per run. Legal range 1..65535.
- `LFSR_SEED`, default 8'hA5: initial LFSR value. A value of 0 is replaced by 8'h01.
- `clk` input 1: system clock. All logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: level. Sampled only in IDLE or DONE.
- `dut_clk` output 1: clock driven to the flop under test. Registered.
- `dut_d` output 1: data driven to the flop under test. Registered.
- `dut_q` input 1: flop `q`. Asynchronous; double-synchronized internally.
- `dut_notq` input 1: flop `notq`. Asynchronous; double-synchronized internally.
- `busy` output 1: high in every state except IDLE and DONE.
- `done` output 1: high in DONE. Held until a new start or reset.
- `pass` output 1: high in DONE when `err_cnt`==0, otherwise 0.
- `err_cnt` output 8: mismatch count. Saturates at 255.

## Operation
- States: IDLE, SETUP, RISE, DISTURB, CHECK, FALL, DONE. A phase counter counts 0..PHASE_CYC-1 in SETUP, RISE, DISTURB and FALL; CHECK lasts exactly 1 cycle.
- **IDLE:** `dut_clk`=0, `dut_d`=0. If `start`=1, load the LFSR with the seed, clear the vector counter and `err_cnt`, and go to SETUP.
- **SETUP:** `dut_clk`=0, `dut_d`=`lfsr[0]`. Latch `exp`=`lfsr[0]`.
- **RISE:** `dut_clk`=1, `dut_d`=`exp`. The flop captures on this edge.
- **DISTURB:** `dut_clk`=1, `dut_d`=~`exp`. A correct edge-triggered flop must not follow this change.
- **CHECK:** `dut_clk`=1, `dut_d`=~`exp`. Compare the synchronized inputs: mismatch if `q_s`!=`exp` or `notq_s`!=~`exp`. Each mismatching vector adds exactly 1 to `err_cnt`, saturating at 255. Then go to FALL.
- **FALL:** `dut_clk`=0, `dut_d`=~`exp`. On the last phase cycle:
  - advance the LFSR;
  - increment the vector counter;
  - if the count has reached NUM_VECT, go to DONE, otherwise go to SETUP.
- **DONE:** `done`=1, `pass`=(`err_cnt`==0), `dut_clk`=0, `dut_d`=0. `start`=1 restarts exactly as from IDLE, clearing `err_cnt`.
- **LFSR:** 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. Shift left, new `lfsr[0]` = b7^b5^b4^b3. Period 255.
- `start` is ignored while `busy`=1.

## Timing
- **Reset:** while `rst_n`=0, asynchronously force:
  - state IDLE;
  - `dut_clk`=0, `dut_d`=0;
  - `busy`=0, `done`=0, `pass`=0, `err_cnt`=0;
  - LFSR = seed, counters = 0, synchronizers = 0.
- **Reset mid-run:** the run is abandoned and `dut_clk` falls within the assertion. After release the block sits in IDLE until `start`.
- All outputs are registered; no combinational path from inputs to outputs.
- **Start:** `busy` rises on the first edge that samples `start`=1.
- **Vector period:** 4·PHASE_CYC+1 cycles. `dut_clk` is high for 2·PHASE_CYC+1 cycles per vector.
- **Run length:** `done` rises exactly NUM_VECT·(4·PHASE_CYC+1) cycles after `busy` rises. `busy` falls on the same edge.
- **Synchronizer latency:** `dut_q` is sampled in CHECK, 2·PHASE_CYC cycles after the `dut_clk` rising edge. The synchronizer has 2 cycles of latency, so the compared value reflects the flop state during DISTURB.
- **Saturation:** `err_cnt` at 255 stays at 255 on further mismatches.

## Test plan
- **Correct flop:** connect a behavioural posedge DFF, defaults, pulse `start` → `done`=1 after 256·17=4352 cycles, `pass`=1, `err_cnt`=0. The `dut_d` sequence seen at RISE matches the bench LFSR model from seed 8'hA5.
- **Stuck-at-0 q:** `dut_q` tied 0, `dut_notq` tied 1 → `err_cnt` equals the bench-counted number of `exp`=1 vectors over 256 vectors (129), `pass`=0.
- **Transparent latch:** replace the flop with a level-sensitive latch (transparent while clock high) → every vector fails in CHECK, so 256 failures saturate `err_cnt` at 255, `pass`=0.
- **Bad complement:** `dut_notq` tied to `dut_q` → all vectors mismatch, `err_cnt`=255, `pass`=0.
- **Reset mid-run:** assert `rst_n`=0 in vector 10 while `dut_clk`=1 → `dut_clk`, `dut_d`, `busy`, `err_cnt` are 0 immediately. After release and `start`, a full correct run gives `pass`=1.
- **Short run:** set NUM_VECT=1, PHASE_CYC=3; pulse `start` during `busy` (ignored), then again in DONE → each run's `done` arrives exactly 13 cycles after its `busy` rise, and `err_cnt` clears on restart.

Source files
------------

// File: rtl/dff_exerciser_if.sv
// Pin bundle between the exerciser (master) and the gate-level D flip-flop under test (slave).
interface dff_exerciser_if;
  logic dut_clk;
  logic dut_d;
  logic dut_q;
  logic dut_notq;

  modport master (output dut_clk, output dut_d, input dut_q, input dut_notq);
  modport slave  (input dut_clk, input dut_d, output dut_q, output dut_notq);
endinterface

// File: rtl/dff_exerciser.sv
// Drives a pseudo-random bit stream into an external D flip-flop, wiggles d while its clock is
// high to prove edge capture, and counts q/notq mismatches. All outputs are registered.
module dff_exerciser #(
  parameter int         PHASE_CYC = 4,
  parameter int         NUM_VECT  = 256,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  dff_exerciser_if.master         flop,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [7:0]              err_cnt,
  output logic [2:0]              state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_RISE, S_DISTURB, S_CHECK, S_FALL, S_DONE
  } state_t;

  localparam logic [7:0]  SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [7:0]  PH_LAST  = 8'(PHASE_CYC - 1);
  localparam logic [15:0] VEC_LAST = 16'(NUM_VECT - 1);

  state_t      state;
  logic [7:0]  phase;
  logic [15:0] vec_cnt;
  logic [7:0]  lfsr;
  logic        exp_bit;
  logic        dut_clk_r;
  logic        dut_d_r;
  logic        q_meta, q_s, notq_meta, notq_s;

  logic [7:0]  lfsr_next;
  logic        ph_last;
  logic        mismatch;

  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign ph_last   = (phase == PH_LAST);
  assign mismatch  = (q_s != exp_bit) || (notq_s != ~exp_bit);

  assign flop.dut_clk = dut_clk_r;
  assign flop.dut_d   = dut_d_r;
  assign state_dbg    = state;

  // q/notq come from an unclocked flop; two stages before anything looks at them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_meta    <= 1'b0;
      q_s       <= 1'b0;
      notq_meta <= 1'b0;
      notq_s    <= 1'b0;
    end else begin
      q_meta    <= flop.dut_q;
      q_s       <= q_meta;
      notq_meta <= flop.dut_notq;
      notq_s    <= notq_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      phase     <= 8'd0;
      vec_cnt   <= 16'd0;
      lfsr      <= SEED;
      exp_bit   <= 1'b0;
      dut_clk_r <= 1'b0;
      dut_d_r   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_SETUP;
            phase     <= 8'd0;
            vec_cnt   <= 16'd0;
            lfsr      <= SEED;
            exp_bit   <= SEED[0];
            dut_d_r   <= SEED[0];
            dut_clk_r <= 1'b0;
            err_cnt   <= 8'd0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
          end
        end
        S_SETUP: begin
          phase <= ph_last ? 8'd0 : phase + 8'd1;
          if (ph_last) begin
            state     <= S_RISE;
            dut_clk_r <= 1'b1;
          end
        end
        S_RISE: begin
          phase <= ph_last ? 8'd0 : phase + 8'd1;
          if (ph_last) begin
            state   <= S_DISTURB;
            dut_d_r <= ~exp_bit;
          end
        end
        S_DISTURB: begin
          phase <= ph_last ? 8'd0 : phase + 8'd1;
          if (ph_last) state <= S_CHECK;
        end
        S_CHECK: begin
          if (mismatch && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
          state     <= S_FALL;
          dut_clk_r <= 1'b0;
        end
        S_FALL: begin
          phase <= ph_last ? 8'd0 : phase + 8'd1;
          if (ph_last) begin
            lfsr    <= lfsr_next;
            vec_cnt <= vec_cnt + 16'd1;
            if (vec_cnt == VEC_LAST) begin
              state   <= S_DONE;
              dut_d_r <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (err_cnt == 8'd0);
            end else begin
              state   <= S_SETUP;
              exp_bit <= lfsr_next[0];
              dut_d_r <= lfsr_next[0];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dff_exerciser.sv
// Bench for dff_exerciser: behavioural flop models with injectable faults, a dut_d scoreboard
// fed from an LFSR model, and run-length / error-count checks on a long and a short instance.
module tb_dff_exerciser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- long instance (defaults) ----------------
  dff_exerciser_if if0 ();
  logic       start0 = 1'b0;
  logic       busy0, done0, pass0;
  logic [7:0] err0;
  logic [2:0] st0;
  logic [1:0] mode0 = 2'd0;   // 0 good flop, 1 stuck q=0, 2 transparent latch, 3 notq==q

  dff_exerciser u_long (
    .clk(clk), .rst_n(rst_n), .start(start0), .flop(if0.master),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .state_dbg(st0)
  );

  logic ff0 = 1'b0;
  logic lat0 = 1'b0;
  always @(posedge if0.dut_clk) ff0 <= if0.dut_d;
  always @(if0.dut_clk or if0.dut_d) if (if0.dut_clk) lat0 = if0.dut_d;
  assign if0.dut_q    = (mode0 == 2'd1) ? 1'b0 : (mode0 == 2'd2) ? lat0 : ff0;
  assign if0.dut_notq = (mode0 == 2'd1) ? 1'b1 : (mode0 == 2'd2) ? ~lat0 :
                        (mode0 == 2'd3) ? ff0 : ~ff0;

  // ---------------- short instance ----------------
  dff_exerciser_if if1 ();
  logic       start1 = 1'b0;
  logic       busy1, done1, pass1;
  logic [7:0] err1;
  logic [2:0] st1;
  logic [1:0] mode1 = 2'd0;

  dff_exerciser #(.PHASE_CYC(3), .NUM_VECT(1)) u_short (
    .clk(clk), .rst_n(rst_n), .start(start1), .flop(if1.master),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .state_dbg(st1)
  );

  logic ff1 = 1'b0;
  always @(posedge if1.dut_clk) ff1 <= if1.dut_d;
  assign if1.dut_q    = ff1;
  assign if1.dut_notq = (mode1 == 2'd3) ? ff1 : ~ff1;

  int hi_cnt1 = 0;
  always @(negedge clk) if (if1.dut_clk) hi_cnt1++;

  // ---------------- scoreboard on dut_d at each flop rising edge ----------------
  logic [0:0] exp_q[$];
  int   rise_cnt0 = 0;
  logic prev_clk0 = 1'b0;
  logic sb_bit;

  always @(negedge clk) begin
    if (if0.dut_clk && !prev_clk0) begin
      rise_cnt0++;
      if (exp_q.size() > 0) begin
        sb_bit = exp_q.pop_front();
        check("sb_dut_d_at_rise", 32'(if0.dut_d), 32'(sb_bit));
      end else begin
        check("sb_unexpected_vector", 32'(exp_q.size()), 32'd1);
      end
    end
    prev_clk0 = if0.dut_clk;
  end

  // Fills the scoreboard for a run and returns the err_cnt a given flop model should produce.
  task automatic load_run(input logic [1:0] m, output int exp_err);
    logic [7:0] l;
    int ones;
    l = 8'hA5;
    ones = 0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(l[0]);
      if (l[0]) ones++;
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    case (m)
      2'd0:    exp_err = 0;
      2'd1:    exp_err = (ones > 255) ? 255 : ones;
      default: exp_err = 255;
    endcase
  endtask

  task automatic pulse_start0();
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic run_long(input string tag, input logic [1:0] m);
    int exp_err;
    int t_busy;
    int t_done;
    mode0 = m;
    load_run(m, exp_err);
    rise_cnt0 = 0;
    pulse_start0();
    t_busy = cyc;
    check({tag, "_busy_rise"}, 32'(busy0), 32'd1);
    t_done = -1;
    for (int k = 0; k < 6000; k++) begin
      if (done0) begin
        t_done = cyc;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_run_len"}, 32'(t_done - t_busy), 32'd4352);
    check({tag, "_busy_fall"}, 32'(busy0), 32'd0);
    check({tag, "_err_cnt"}, 32'(err0), 32'(exp_err));
    check({tag, "_pass"}, 32'(pass0), (exp_err == 0) ? 32'd1 : 32'd0);
    check({tag, "_vectors_seen"}, 32'(exp_q.size()), 32'd0);
  endtask

  int t_b1;
  int t_d1;

  initial begin
    // Reset values.
    #12;
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_pass", 32'(pass0), 32'd0);
    check("rst_err", 32'(err0), 32'd0);
    check("rst_dut_clk", 32'(if0.dut_clk), 32'd0);
    check("rst_dut_d", 32'(if0.dut_d), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_start", 32'(busy0), 32'd0);

    // Short run with a bad-complement flop, extra start during busy.
    mode1 = 2'd3;
    hi_cnt1 = 0;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    t_b1 = cyc;
    check("short1_busy_rise", 32'(busy1), 32'd1);
    repeat (4) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    t_d1 = -1;
    for (int k = 0; k < 100; k++) begin
      if (done1) begin
        t_d1 = cyc;
        break;
      end
      @(negedge clk);
    end
    check("short1_run_len", 32'(t_d1 - t_b1), 32'd13);
    check("short1_clk_high", 32'(hi_cnt1), 32'd7);
    check("short1_err", 32'(err1), 32'd1);
    check("short1_pass", 32'(pass1), 32'd0);
    repeat (5) @(negedge clk);
    check("short1_done_held", 32'(done1), 32'd1);

    // Restart from DONE with a good flop; err_cnt must clear.
    mode1 = 2'd0;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    t_b1 = cyc;
    check("short2_busy_rise", 32'(busy1), 32'd1);
    check("short2_err_cleared", 32'(err1), 32'd0);
    check("short2_done_cleared", 32'(done1), 32'd0);
    t_d1 = -1;
    for (int k = 0; k < 100; k++) begin
      if (done1) begin
        t_d1 = cyc;
        break;
      end
      @(negedge clk);
    end
    check("short2_run_len", 32'(t_d1 - t_b1), 32'd13);
    check("short2_pass", 32'(pass1), 32'd1);

    // Full-length runs against each flop model.
    run_long("good", 2'd0);
    run_long("stuck0", 2'd1);
    run_long("latch", 2'd2);
    run_long("badcomp", 2'd3);

    // Reset in vector 10 while the flop clock is high.
    mode0 = 2'd0;
    begin
      int dummy;
      load_run(2'd0, dummy);
    end
    rise_cnt0 = 0;
    pulse_start0();
    for (int k = 0; k < 2000; k++) begin
      if (rise_cnt0 >= 10) break;
      @(negedge clk);
    end
    #2;
    check("mid_dut_clk_high", 32'(if0.dut_clk), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_dut_clk", 32'(if0.dut_clk), 32'd0);
    check("mid_rst_dut_d", 32'(if0.dut_d), 32'd0);
    check("mid_rst_busy", 32'(busy0), 32'd0);
    check("mid_rst_err", 32'(err0), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_idle_after_rel", 32'(busy0), 32'd0);
    run_long("after_rst", 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
